instr_prefetch_queue: RTL and testbench

Fetch-side prefetcher sitting directly upstream of the instruction fetch stage. It issues sequential word fetches to instruction memory over a request/grant/response handshake. It buffers returned instructions with their PCs in a small FIFO and presents them to the fetch stage with a valid/ready interface. A taken branch from the memory stage redirects it: the queue is flushed, the in-flight response is discarded, and fetching restarts at the target.

---
 rtl/riscv_pipe_pkg.sv | 15 +
 rtl/prefetch_fifo.sv | 64 ++++++
 rtl/instr_prefetch_queue.sv | 126 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline types and constants
// Purpose: prefetcher state encoding, datapath width and the canonical NOP.
// Ports: none (package).
package riscv_pipe_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } pf_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// rtl/prefetch_fifo.sv - synchronous FIFO of {pc, instr} pairs
// Purpose: buffers fetched instructions with their PCs; flush beats push/pop.
// Ports: clk, reset (async active-low), push/push_pc/push_instr (write side),
//        pop (read side), flush (empty the queue), head_pc/head_instr (head
//        entry registers), count (occupancy, 0..DEPTH).
module prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_pc,
  input  logic [W-1:0]  push_instr,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_pc,
  output logic [W-1:0]  head_instr,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [W-1:0]  pc_mem    [DEPTH];
  logic [W-1:0]  instr_mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push    = push && (count != CW'(DEPTH));
  assign do_pop     = pop && (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction prefetcher with redirect
// Purpose: issues word fetches over req/gnt/rvalid, queues responses with PCs,
//          flushes and restarts at the branch target on redirect.
// Ports: clk, reset (async active-low);
//        mem_req/mem_addr/mem_gnt/mem_rvalid/mem_rdata (instruction memory);
//        redirect/redirect_addr (taken branch from memory stage);
//        out_valid/out_instr/out_pc/out_ready (fetch stage).
module instr_prefetch_queue
  import riscv_pipe_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  pf_state_t       state;
  pf_state_t       state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic            discard;
  logic            discard_next;
  logic [CW-1:0]   count;
  logic [CW:0]     count_after;
  logic            credit;
  logic            resp;
  logic            push;
  logic            pop;
  logic            addr_lsb_unused;

  assign addr_lsb_unused = ^redirect_addr[1:0];

  assign resp      = (state == WAIT) && mem_rvalid;
  assign push      = resp && !discard && !redirect;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);

  // Credit is judged on the occupancy the FIFO will have after this edge,
  // at a point where nothing is outstanding (IDLE, or WAIT as it completes).
  always_comb begin
    count_after = '0;
    if (!redirect) begin
      count_after = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop);
    end
  end

  assign credit = (count_after < (CW+1)'(DEPTH));

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    discard_next  = discard;

    case (state)
      IDLE:    if (credit) state_next = REQ;
      REQ:     if (mem_gnt) state_next = WAIT;
      WAIT:    if (mem_rvalid) state_next = credit ? REQ : IDLE;
      default: state_next = IDLE;
    endcase

    // A grant of a stale (discarded) request must not advance the target PC.
    if (redirect) begin
      fetch_pc_next = {redirect_addr[XLEN-1:2], 2'b00};
    end else if ((state == REQ) && mem_gnt && !discard) begin
      fetch_pc_next = fetch_pc + 32'd4;
    end

    // A response arriving on the redirect edge is itself the stale one, so
    // nothing remains outstanding to drop afterwards.
    if (redirect) begin
      discard_next = (state == REQ) || ((state == WAIT) && !mem_rvalid);
    end else if (resp) begin
      discard_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      discard  <= discard_next;
      mem_req  <= (state_next == REQ);
      // Address only moves when a new handshake starts.
      if ((state_next == REQ) && (state != REQ)) begin
        mem_addr <= fetch_pc_next;
      end
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .W     (XLEN)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (mem_addr),
    .push_instr (mem_rdata),
    .pop        (pop),
    .flush      (redirect),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .count      (count)
  );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  int          checks = 0;
  int          errors = 0;

  int          lat = 1;
  bit          auto_rsp = 1'b1;
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          grants = 0;
  logic [31:0] seen[$];

  always #5 clk = ~clk;

  instr_prefetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_ready     (out_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One clock: log consumptions, check request address hold, run memory model.
  task automatic tick();
    bit          g;
    bit          hold;
    logic [31:0] a;
    g    = (mem_req === 1'b1) && (mem_gnt === 1'b1);
    hold = (mem_req === 1'b1) && (mem_gnt === 1'b0);
    a    = mem_addr;
    if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
      seen.push_back(out_pc);
      chk("instr_vs_pc", out_instr, out_pc ^ K);
    end
    @(posedge clk);
    #1;
    if (hold && (reset === 1'b1) && (mem_req === 1'b1)) chk("addr_hold", mem_addr, a);
    if (auto_rsp) begin
      mem_rvalid = 1'b0;
      if (g) begin
        pend      = 1'b1;
        pend_cnt  = lat;
        pend_addr = a;
        grants++;
      end
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          pend       = 1'b0;
          mem_rvalid = 1'b1;
          mem_rdata  = pend_addr ^ K;
        end
      end
    end
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    mem_rvalid = 1'b0;
    pend       = 1'b0;
    redirect   = 1'b0;
    repeat (2) tick();
    seen.delete();
    grants = 0;
    reset  = 1'b1;
  endtask

  task automatic wait_seen(input int n, input int budget);
    int k;
    k = 0;
    while ((seen.size() < n) && (k < budget)) begin
      tick();
      k++;
    end
    chk("wait_seen", seen.size(), n);
  endtask

  initial begin
    int k;
    reset         = 1'b0;
    mem_gnt       = 1'b1;
    mem_rvalid    = 1'b0;
    mem_rdata     = '0;
    redirect      = 1'b0;
    redirect_addr = '0;
    out_ready     = 1'b1;

    // Reset state
    repeat (2) tick();
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    reset = 1'b1;
    chk("rel_req_low", mem_req, 1'b0);
    tick();
    chk("first_req", mem_req, 1'b1);
    chk("first_addr", mem_addr, 32'h0);

    // Streaming from reset
    wait_seen(4, 40);
    chk("t1_pc0", seen[0], 32'h0);
    chk("t1_pc1", seen[1], 32'h4);
    chk("t1_pc2", seen[2], 32'h8);
    chk("t1_pc3", seen[3], 32'hC);

    // Stall fills exactly DEPTH entries, then drains in order and resumes
    out_ready = 1'b0;
    do_reset();
    repeat (20) tick();
    chk("t2_grants", grants, 4);
    chk("t2_req_low", mem_req, 1'b0);
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_head_pc", out_pc, 32'h0);
    chk("t2_head_instr", out_instr, 32'hA5A5_0000);
    out_ready = 1'b1;
    wait_seen(5, 40);
    chk("t2_pc0", seen[0], 32'h0);
    chk("t2_pc1", seen[1], 32'h4);
    chk("t2_pc2", seen[2], 32'h8);
    chk("t2_pc3", seen[3], 32'hC);
    chk("t2_pc4", seen[4], 32'h10);

    // Redirect while in WAIT, response lands two cycles later
    lat = 3;
    k = 0;
    while (!((mem_req === 1'b1) && (mem_gnt === 1'b1)) && (k < 20)) begin
      tick();
      k++;
    end
    chk("t3_found_gnt", mem_req, 1'b1);
    tick();
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    seen.delete();
    chk("t3_valid_a", out_valid, 1'b0);
    tick();
    chk("t3_valid_b", out_valid, 1'b0);
    tick();
    chk("t3_valid_c", out_valid, 1'b0);
    chk("t3_req", mem_req, 1'b1);
    chk("t3_addr", mem_addr, 32'h100);
    wait_seen(2, 60);
    chk("t3_pc0", seen[0], 32'h100);
    chk("t3_pc1", seen[1], 32'h104);

    // Redirect while in REQ with grant held off three cycles
    lat     = 1;
    mem_gnt = 1'b0;
    do_reset();
    tick();
    chk("t4_req", mem_req, 1'b1);
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("t4_addr_a", mem_addr, 32'h0);
    chk("t4_valid", out_valid, 1'b0);
    tick();
    chk("t4_addr_b", mem_addr, 32'h0);
    tick();
    chk("t4_addr_c", mem_addr, 32'h0);
    chk("t4_req_c", mem_req, 1'b1);
    mem_gnt = 1'b1;
    tick();
    chk("t4_wait", mem_req, 1'b0);
    tick();
    chk("t4_req2", mem_req, 1'b1);
    chk("t4_addr2", mem_addr, 32'h200);
    chk("t4_valid2", out_valid, 1'b0);
    wait_seen(1, 20);
    chk("t4_pc0", seen[0], 32'h200);

    // Redirect + pop + rvalid on the same edge with two entries queued
    out_ready = 1'b0;
    do_reset();
    repeat (6) tick();
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_head", out_pc, 32'h0);
    chk("t5_wait", mem_req, 1'b0);
    out_ready     = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 32'h0000_0300;
    tick();
    redirect = 1'b0;
    seen.delete();
    chk("t5_empty", out_valid, 1'b0);
    chk("t5_req", mem_req, 1'b1);
    chk("t5_addr", mem_addr, 32'h300);
    wait_seen(1, 20);
    chk("t5_pc0", seen[0], 32'h300);

    // Reset mid-WAIT, then a stray response
    out_ready = 1'b0;
    lat       = 1;
    do_reset();
    repeat (4) tick();
    chk("t6_pre_addr", mem_addr, 32'h4);
    chk("t6_pre_valid", out_valid, 1'b1);
    auto_rsp = 1'b0;
    pend     = 1'b0;
    reset    = 1'b0;
    #1;
    seen.delete();
    chk("t6_rst_req", mem_req, 1'b0);
    chk("t6_rst_addr", mem_addr, 32'h0);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_pc", out_pc, 32'h0);
    chk("t6_rst_instr", out_instr, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_stray_valid", out_valid, 1'b0);
    chk("t6_req", mem_req, 1'b1);
    chk("t6_addr", mem_addr, 32'h0);
    mem_rvalid = 1'b0;
    auto_rsp   = 1'b1;
    out_ready  = 1'b1;
    wait_seen(1, 20);
    chk("t6_pc0", seen[0], 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
